// File: rtl/ship_datapath.sv
// Player ship: button movement, hit damage with i-frames, cooldown-limited fire requests held until acked.
// One-cycle update on the rising edge of shipUpdateEn; optional SHIP_AUTOFIRE_EN fires on every eligible tick.
module ship_datapath #(
   parameter int X_MAX         = 152,
   parameter int Y_MAX         = 112,
   parameter int START_X       = 8,
   parameter int START_Y       = 56,
   parameter int SHIP_W        = 8,
   parameter int SHIP_H        = 8,
   parameter int HEALTH_INIT   = 3,
   parameter int IFRAMES       = 16,
   parameter int FIRE_COOLDOWN = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       startGameEn,
   input  logic       shipUpdateEn,
   input  logic       gameOverEn,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_fire,
   input  logic       hit,
   input  logic       fire_ack,
   output logic [7:0] ship_x,
   output logic [6:0] ship_y,
   output logic [7:0] ship_health,
   output logic       fire_req,
   output logic [7:0] fire_x,
   output logic [6:0] fire_y,
   output logic       invuln
);
   localparam int IW = $clog2(IFRAMES + 1);
   localparam int CW = $clog2(FIRE_COOLDOWN + 1);
   localparam logic [7:0]    XMAX  = 8'(X_MAX);
   localparam logic [6:0]    YMAX  = 7'(Y_MAX);
   localparam logic [7:0]    X0    = 8'(START_X);
   localparam logic [6:0]    Y0    = 7'(START_Y);
   localparam logic [7:0]    H0    = 8'(HEALTH_INIT);
   localparam logic [IW-1:0] IF0   = IW'(IFRAMES);
   localparam logic [CW-1:0] CD0   = CW'(FIRE_COOLDOWN);
   localparam logic [8:0]    OFS_X = 9'(SHIP_W);
   localparam logic [6:0]    OFS_Y = 7'(SHIP_H / 2);

   typedef enum logic [1:0] {S_PLAY, S_INVULN, S_DEAD} state_t;

   state_t          state, state_nxt;
   logic            upd_q, hit_pend, hit_pend_nxt;
   logic [IW-1:0]   iframe, iframe_nxt;
   logic [CW-1:0]   cooldown, cooldown_nxt, cd_dec;
   logic [7:0]      x_nxt, move_x, health_nxt, fx_nxt;
   logic [6:0]      y_nxt, move_y, fy_nxt;
   logic [8:0]      fx_sum;
   logic            fire_req_nxt, tick, upd, dmg, fire_btn;

`ifdef SHIP_AUTOFIRE_EN
   assign fire_btn = 1'b1;
`else
   assign fire_btn = btn_fire;
`endif

   assign tick   = shipUpdateEn & ~upd_q;
   assign upd    = tick & ~gameOverEn & ~startGameEn;
   assign dmg    = hit_pend | hit;
   assign cd_dec = (cooldown != '0) ? cooldown - 1'b1 : '0;
   assign invuln = (state == S_INVULN);

   always_comb begin
      move_x = ship_x;
      move_y = ship_y;
      if (btn_right && !btn_left && ship_x < XMAX)
         move_x = ship_x + 8'd1;
      else if (btn_left && !btn_right && ship_x != 8'd0)
         move_x = ship_x - 8'd1;
      if (btn_down && !btn_up && ship_y < YMAX)
         move_y = ship_y + 7'd1;
      else if (btn_up && !btn_down && ship_y != 7'd0)
         move_y = ship_y - 7'd1;
      fx_sum = {1'b0, move_x} + OFS_X;
   end

   always_comb begin
      state_nxt    = state;
      x_nxt        = ship_x;
      y_nxt        = ship_y;
      health_nxt   = ship_health;
      iframe_nxt   = iframe;
      cooldown_nxt = cooldown;
      fx_nxt       = fire_x;
      fy_nxt       = fire_y;
      hit_pend_nxt = hit_pend | (hit & ~gameOverEn);
      fire_req_nxt = fire_req & ~fire_ack & ~gameOverEn;

      if (startGameEn) begin
         state_nxt    = S_PLAY;
         x_nxt        = X0;
         y_nxt        = Y0;
         health_nxt   = H0;
         iframe_nxt   = '0;
         cooldown_nxt = '0;
         hit_pend_nxt = 1'b0;
         fire_req_nxt = 1'b0;
      end else if (upd) begin
         hit_pend_nxt = 1'b0;
         cooldown_nxt = cd_dec;
         case (state)
            S_PLAY: begin
               if (dmg) begin
                  health_nxt = (ship_health != 8'd0) ? ship_health - 8'd1 : 8'd0;
                  if (ship_health <= 8'd1) begin
                     state_nxt = S_DEAD;
                  end else begin
                     state_nxt  = S_INVULN;
                     iframe_nxt = IF0;
                  end
               end
            end
            S_INVULN: begin
               iframe_nxt = (iframe != '0) ? iframe - 1'b1 : '0;
               if (iframe <= IW'(1))
                  state_nxt = S_PLAY;
            end
            default: ;
         endcase
         if (state != S_DEAD) begin
            x_nxt = move_x;
            y_nxt = move_y;
         end
         // Cooldown is checked after this tick's decrement so shots land FIRE_COOLDOWN ticks apart.
         if (state_nxt != S_DEAD && fire_btn && cd_dec == '0 && !fire_req) begin
            fire_req_nxt = 1'b1;
            fx_nxt       = fx_sum[8] ? 8'hFF : fx_sum[7:0];
            fy_nxt       = move_y + OFS_Y;
            cooldown_nxt = CD0;
         end
         if (state_nxt == S_DEAD)
            fire_req_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= S_PLAY;
         upd_q       <= 1'b0;
         hit_pend    <= 1'b0;
         iframe      <= '0;
         cooldown    <= '0;
         ship_x      <= X0;
         ship_y      <= Y0;
         ship_health <= H0;
         fire_req    <= 1'b0;
         fire_x      <= 8'd0;
         fire_y      <= 7'd0;
      end else begin
         state       <= state_nxt;
         upd_q       <= shipUpdateEn;
         hit_pend    <= hit_pend_nxt;
         iframe      <= iframe_nxt;
         cooldown    <= cooldown_nxt;
         ship_x      <= x_nxt;
         ship_y      <= y_nxt;
         ship_health <= health_nxt;
         fire_req    <= fire_req_nxt;
         fire_x      <= fx_nxt;
         fire_y      <= fy_nxt;
      end
   end
endmodule

// File: tb/tb_ship_datapath.sv
// Directed bench for ship_datapath: movement, damage/i-frames, death, fire handshake, game over, reset.
module tb_ship_datapath;
   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       startGameEn = 1'b0, shipUpdateEn = 1'b0, gameOverEn = 1'b0;
   logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_fire = 1'b0;
   logic       hit = 1'b0, fire_ack = 1'b0;
   logic [7:0] ship_x, ship_health, fire_x;
   logic [6:0] ship_y, fire_y;
   logic       fire_req, invuln;
   int         checks = 0;
   int         errors = 0;

   ship_datapath dut (
      .clk(clk), .resetn(resetn), .startGameEn(startGameEn), .shipUpdateEn(shipUpdateEn),
      .gameOverEn(gameOverEn), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
      .btn_right(btn_right), .btn_fire(btn_fire), .hit(hit), .fire_ack(fire_ack),
      .ship_x(ship_x), .ship_y(ship_y), .ship_health(ship_health), .fire_req(fire_req),
      .fire_x(fire_x), .fire_y(fire_y), .invuln(invuln)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // shipUpdateEn held for n clock edges, then dropped; returns on a falling edge.
   task automatic do_tick(input int n);
      @(negedge clk) shipUpdateEn = 1'b1;
      repeat (n) @(negedge clk);
      shipUpdateEn = 1'b0;
   endtask

   task automatic pulse_hit();
      @(negedge clk) hit = 1'b1;
      @(negedge clk) hit = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk) startGameEn = 1'b1;
      @(negedge clk) startGameEn = 1'b0;
   endtask

   initial begin
      // reset values
      #25;
      chk("rst_x", ship_x, 8);
      chk("rst_y", ship_y, 56);
      chk("rst_health", ship_health, 3);
      chk("rst_fire_req", fire_req, 0);
      chk("rst_fire_x", fire_x, 0);
      chk("rst_fire_y", fire_y, 0);
      chk("rst_invuln", invuln, 0);
      @(negedge clk) resetn = 1'b1;
      pulse_start();
      chk("start_x", ship_x, 8);
      chk("start_y", ship_y, 56);
      chk("start_health", ship_health, 3);
      chk("start_fire_req", fire_req, 0);

      // right movement, one pixel per update, saturating at 152
      btn_right = 1'b1;
      for (int i = 1; i <= 200; i++) begin
         do_tick(5);
         if (i == 1)   chk("move_first", ship_x, 9);
         if (i == 143) chk("move_143", ship_x, 151);
         if (i == 144) chk("move_144", ship_x, 152);
      end
      chk("move_sat", ship_x, 152);
      chk("move_y_hold", ship_y, 56);
      btn_right = 1'b0;

      // damage and invulnerability window
      pulse_start();
      chk("restart_x", ship_x, 8);
      pulse_hit();
      do_tick(2);
      chk("hit1_health", ship_health, 2);
      chk("hit1_invuln", invuln, 1);
      for (int i = 1; i <= 15; i++) begin
         pulse_hit();
         do_tick(2);
      end
      chk("iframe15_health", ship_health, 2);
      chk("iframe15_invuln", invuln, 1);
      do_tick(2);
      chk("iframe16_invuln", invuln, 0);
      chk("iframe16_health", ship_health, 2);

      // two more damaging hits reach death
      pulse_hit();
      do_tick(2);
      chk("hit2_health", ship_health, 1);
      for (int i = 1; i <= 16; i++) do_tick(2);
      chk("hit2_recover", invuln, 0);
      pulse_hit();
      do_tick(2);
      chk("dead_health", ship_health, 0);
      chk("dead_invuln", invuln, 0);
      btn_right = 1'b1;
      btn_fire  = 1'b1;
      do_tick(2);
      do_tick(2);
      chk("dead_x_frozen", ship_x, 8);
      chk("dead_no_fire", fire_req, 0);
      pulse_hit();
      do_tick(2);
      chk("dead_health_floor", ship_health, 0);
      btn_right = 1'b0;
      btn_fire  = 1'b0;
      pulse_start();
      chk("revive_health", ship_health, 3);
      chk("revive_x", ship_x, 8);
      chk("revive_y", ship_y, 56);

      // move to (20,40)
      btn_up = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         btn_right = (i <= 12);
         do_tick(2);
      end
      btn_up    = 1'b0;
      btn_right = 1'b0;
      chk("pos_x", ship_x, 20);
      chk("pos_y", ship_y, 40);

      // fire, handshake, cooldown
      btn_fire = 1'b1;
      do_tick(2);
      chk("fire_req", fire_req, 1);
      chk("fire_x", fire_x, 28);
      chk("fire_y", fire_y, 44);
      repeat (6) @(negedge clk);
      chk("fire_hold", fire_req, 1);
      chk("fire_x_stable", fire_x, 28);
      fire_ack = 1'b1;
      @(negedge clk) fire_ack = 1'b0;
      chk("fire_acked", fire_req, 0);
      for (int i = 1; i <= 3; i++) begin
         do_tick(2);
         chk("cooldown_block", fire_req, 0);
      end
      do_tick(2);
      chk("cooldown_fire", fire_req, 1);

      // game over drops fire_req and freezes the ship
      @(negedge clk) gameOverEn = 1'b1;
      @(negedge clk);
      chk("gameover_fire", fire_req, 0);
      btn_down = 1'b1;
      do_tick(2);
      chk("gameover_y_hold", ship_y, 40);
      chk("gameover_health", ship_health, 3);
      btn_down   = 1'b0;
      btn_fire   = 1'b0;
      gameOverEn = 1'b0;

      // asynchronous reset mid fire_req and mid invulnerability
      pulse_start();
      btn_fire  = 1'b1;
      btn_right = 1'b1;
      pulse_hit();
      do_tick(2);
      chk("pre_rst_req", fire_req, 1);
      chk("pre_rst_invuln", invuln, 1);
      chk("pre_rst_x", ship_x, 9);
      chk("pre_rst_fire_x", fire_x, 17);
      btn_fire  = 1'b0;
      btn_right = 1'b0;
      #3 resetn = 1'b0;
      #1;
      chk("arst_x", ship_x, 8);
      chk("arst_y", ship_y, 56);
      chk("arst_health", ship_health, 3);
      chk("arst_fire_req", fire_req, 0);
      chk("arst_fire_x", fire_x, 0);
      chk("arst_fire_y", fire_y, 0);
      chk("arst_invuln", invuln, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
